time_remaining_display: RTL and testbench

TIME_REMAINING_DISPLAY -- requirements
Module: time_remaining_display

---
 rtl/time_remaining_display.sv | 133 +++++++++++++
 tb/tb_time_remaining_display.sv | 112 +++++++++++
 2 files changed

// File: rtl/time_remaining_display.sv
// Converts remaining game time (TIME_LIMIT - timeElapsed) to three 7-segment digits via a serial double-dabble.
// Optional low-time blinker compiled in with `define BLINK_WARNING_EN.
module time_remaining_display #(
    parameter logic [6:0]  TIME_LIMIT = 7'd100,
    parameter logic [25:0] BLINK_DIV  = 26'd12_500_000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [6:0] timeElapsed,
    input  logic       noMoreTime,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic       convBusy
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t      state;
    logic [6:0]  lastSample;
    logic [6:0]  bin;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic [2:0]  iter;
    logic [3:0]  dig2, dig1, dig0;
    logic        blank_all;

    function automatic logic [3:0] adj3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    assign bcd_adj = {adj3(bcd[11:8]), adj3(bcd[7:4]), adj3(bcd[3:0])};

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            convBusy   <= 1'b0;
            lastSample <= 7'h7F;
            bin        <= 7'd0;
            bcd        <= 12'd0;
            iter       <= 3'd0;
            dig2       <= 4'd0;
            dig1       <= 4'd0;
            dig0       <= 4'd0;
        end else begin
            case (state)
                IDLE: if (timeElapsed != lastSample) begin
                    lastSample <= timeElapsed;
                    convBusy   <= 1'b1;
                    state      <= LOAD;
                end
                LOAD: begin
                    // saturate at zero once the limit is passed
                    bin   <= (lastSample <= TIME_LIMIT) ? TIME_LIMIT - lastSample : 7'd0;
                    bcd   <= 12'd0;
                    iter  <= 3'd0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
                    iter       <= iter + 3'd1;
                    if (iter == 3'd6)
                        state <= DONE;
                end
                DONE: begin
                    dig2     <= bcd[11:8];
                    dig1     <= bcd[7:4];
                    dig0     <= bcd[3:0];
                    convBusy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BLINK_WARNING_EN
    logic [25:0] blink_cnt;
    logic        blink_phase;
    logic        low_time;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            blink_cnt   <= BLINK_DIV - 26'd1;
            blink_phase <= 1'b1;
        end else if (blink_cnt == 26'd0) begin
            blink_cnt   <= BLINK_DIV - 26'd1;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt - 26'd1;
        end
    end

    // displayed value in 1..10
    assign low_time  = (dig2 == 4'd0) &&
                       (((dig1 == 4'd0) && (dig0 != 4'd0)) || ((dig1 == 4'd1) && (dig0 == 4'd0)));
    assign blank_all = low_time && !blink_phase;
`else
    assign blank_all = 1'b0;
`endif

    always_comb begin
        HEX2 = (dig2 == 4'd0) ? 7'h7F : seg(dig2);
        HEX1 = ((dig2 == 4'd0) && (dig1 == 4'd0)) ? 7'h7F : seg(dig1);
        HEX0 = seg(dig0);
        if (noMoreTime) begin
            HEX2 = 7'h7F;
            HEX1 = 7'h7F;
            HEX0 = seg(4'd0);
        end else if (blank_all) begin
            HEX2 = 7'h7F;
            HEX1 = 7'h7F;
            HEX0 = 7'h7F;
        end
    end

endmodule

// File: tb/tb_time_remaining_display.sv
// Randomized bench for time_remaining_display against a cycle-count timing model of the conversion.
module tb_time_remaining_display;

    localparam int TL  = 100;
    localparam int DIV = 4;

    logic       clock = 1'b0;
    logic       resetn;
    logic [6:0] te;
    logic       nmt;
    logic [6:0] HEX2, HEX1, HEX0;
    logic       convBusy;

    int n_cmp = 0;
    int n_err = 0;

    // reference state: value on display, last sampled input, cycles left in conversion, cycles since reset
    int shown, last, timer, k;

    logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    time_remaining_display #(.TIME_LIMIT(7'd100), .BLINK_DIV(26'd4)) dut (
        .clock(clock), .resetn(resetn), .timeElapsed(te), .noMoreTime(nmt),
        .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0), .convBusy(convBusy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        int h, t, u;
        logic [6:0] e2, e1, e0;
        @(posedge clock);
        if (!resetn) begin
            shown = 0; last = 127; timer = 0; k = 0;
        end else begin
            k++;
            if (timer == 0) begin
                if (int'(te) != last) begin
                    last  = int'(te);
                    timer = 9;
                end
            end else begin
                timer--;
                if (timer == 0)
                    shown = (last <= TL) ? TL - last : 0;
            end
        end
        #1;
        h = shown / 100; t = (shown / 10) % 10; u = shown % 10;
        e2 = (h == 0) ? 7'h7F : SEG[h];
        e1 = (h == 0 && t == 0) ? 7'h7F : SEG[t];
        e0 = SEG[u];
        if (nmt) begin
            e2 = 7'h7F; e1 = 7'h7F; e0 = SEG[0];
        end
`ifdef BLINK_WARNING_EN
        else if (shown >= 1 && shown <= 10 && ((k / DIV) % 2) == 1) begin
            e2 = 7'h7F; e1 = 7'h7F; e0 = 7'h7F;
        end
`endif
        check("busy", {6'd0, convBusy}, {6'd0, timer != 0});
        check("hex2", HEX2, e2);
        check("hex1", HEX1, e1);
        check("hex0", HEX0, e0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        shown = 0; last = 127; timer = 0; k = 0;
        resetn = 1'b0; te = 7'd0; nmt = 1'b0;
        run(3);
        resetn = 1'b1;
        run(12);                       // shows 100
        te = 7'd37;  run(12);          // shows 63
        te = 7'd10;  run(12);
        te = 7'd20;  run(2);           // change mid-conversion
        te = 7'd10;  run(2);
        te = 7'd20;  run(24);
        te = 7'd95;  run(24);          // low-time region
        te = 7'd90;  run(14);          // exactly 10
        te = 7'd101; run(12);          // saturates to 0
        te = 7'd127; run(12);
        nmt = 1'b1;  te = 7'd95; run(14);
        nmt = 1'b0;  te = 7'd50; run(5);
        resetn = 1'b0; run(1);         // abandon mid-shift
        resetn = 1'b1; run(12);
        for (int r = 0; r < 150; r++) begin
            if ($urandom_range(0, 2) == 0) te = 7'($urandom_range(88, 100));
            else                           te = 7'($urandom_range(0, 127));
            nmt = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) begin
                resetn = 1'b0; run(1); resetn = 1'b1;
            end
            run($urandom_range(1, 14));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
